// File: rtl/data_link_pkg.sv
// Shared definitions for the byte-serial count link (packer and unpacker).
// Frame = NUM_BYTES words of {idx, byte}; bytes 0..3 carry f0_num, 4..7 carry fx_num, LSB first.
package data_link_pkg;

  localparam int IDX_W     = 3;
  localparam int BYTE_W    = 8;
  localparam int NUM_BYTES = 1 << IDX_W;
  localparam int NUM_W     = (NUM_BYTES * BYTE_W) / 2;

  typedef enum logic [0:0] {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } rx_state_t;

endpackage

// File: rtl/data_unpack_sat_counter.sv
// Saturating event counter: +1 per inc cycle, sticks at all-ones, synchronous clear.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/data_unpack.sv
// Receive side of the byte-serial count link: reassembles 8-byte frames into f0_num/fx_num.
// Optional statistics counters (frame_cnt, err_cnt) are built when DATA_UNPACK_STATS_EN is defined.
module data_unpack
  import data_link_pkg::*;
#(
  parameter int IDX_W  = data_link_pkg::IDX_W,
  parameter int BYTE_W = data_link_pkg::BYTE_W,
  parameter int NUM_W  = data_link_pkg::NUM_W,
  parameter int CNT_W  = 16
) (
  input  logic                    read_clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [IDX_W+BYTE_W-1:0] in_num,
  output logic [NUM_W-1:0]        f0_num,
  output logic [NUM_W-1:0]        fx_num,
  output logic                    frame_valid,
  output logic                    frame_err,
  output logic                    busy
`ifdef DATA_UNPACK_STATS_EN
  ,
  output logic [CNT_W-1:0]        frame_cnt,
  output logic [CNT_W-1:0]        err_cnt
`endif
);

  localparam int FRAME_BYTES = 1 << IDX_W;
  localparam int FRAME_W     = FRAME_BYTES * BYTE_W;
  localparam logic [IDX_W-1:0] LAST_IDX = {IDX_W{1'b1}};

  if (2 * NUM_W != FRAME_W) begin : g_bad_width
    $error("data_unpack: 2*NUM_W must equal 2**IDX_W * BYTE_W");
  end
  if (CNT_W < 1) begin : g_bad_cnt
    $error("data_unpack: CNT_W must be at least 1");
  end

  // Handshake: a word is transferred on every read_clk edge where in_valid is high;
  // there is no backpressure, so the receiver must accept every live word.
  logic [IDX_W-1:0]  in_idx;
  logic [BYTE_W-1:0] in_byte;
  assign in_idx  = in_num[IDX_W+BYTE_W-1:BYTE_W];
  assign in_byte = in_num[BYTE_W-1:0];

  rx_state_t         state_q, state_d;
  logic [IDX_W-1:0]  exp_idx_q, exp_idx_d;
  logic [FRAME_W-1:0] shadow_q, shadow_d;
  logic [NUM_W-1:0]  f0_q, f0_d;
  logic [NUM_W-1:0]  fx_q, fx_d;
  logic              frame_valid_q, frame_valid_d;
  logic              frame_err_q, frame_err_d;

  always_comb begin
    state_d       = state_q;
    exp_idx_d     = exp_idx_q;
    shadow_d      = shadow_q;
    f0_d          = f0_q;
    fx_d          = fx_q;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;

    case (state_q)
      HUNT: begin
        // Non-zero indices here mean we joined mid-stream; drop them quietly.
        if (in_valid && (in_idx == '0)) begin
          shadow_d[BYTE_W-1:0] = in_byte;
          exp_idx_d            = IDX_W'(1);
          state_d              = COLLECT;
        end
      end

      COLLECT: begin
        if (!in_valid) begin
          frame_err_d = 1'b1;
          exp_idx_d   = '0;
          state_d     = HUNT;
        end else if (in_idx == exp_idx_q) begin
          shadow_d[int'(in_idx)*BYTE_W +: BYTE_W] = in_byte;
          exp_idx_d = exp_idx_q + IDX_W'(1);
          if (in_idx == LAST_IDX) begin
            // Last byte goes straight to fx_num; the shadow copy is not needed for it.
            f0_d          = shadow_q[NUM_W-1:0];
            fx_d          = {in_byte, shadow_q[FRAME_W-BYTE_W-1:NUM_W]};
            frame_valid_d = 1'b1;
            exp_idx_d     = '0;
            state_d       = HUNT;
          end
        end else begin
          frame_err_d = 1'b1;
          if (in_idx == '0) begin
            shadow_d[BYTE_W-1:0] = in_byte;
            exp_idx_d            = IDX_W'(1);
          end else begin
            exp_idx_d = '0;
            state_d   = HUNT;
          end
        end
      end

      default: begin
        exp_idx_d = '0;
        state_d   = HUNT;
      end
    endcase
  end

  always_ff @(posedge read_clk) begin
    if (rst) begin
      state_q       <= HUNT;
      exp_idx_q     <= '0;
      shadow_q      <= '0;
      f0_q          <= '0;
      fx_q          <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      exp_idx_q     <= exp_idx_d;
      shadow_q      <= shadow_d;
      f0_q          <= f0_d;
      fx_q          <= fx_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign f0_num      = f0_q;
  assign fx_num      = fx_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign busy        = (state_q == COLLECT);

`ifdef DATA_UNPACK_STATS_EN
  sat_counter #(.CNT_W(CNT_W)) u_frame_cnt (
    .clk   (read_clk),
    .clear (rst),
    .inc   (frame_valid_q),
    .count (frame_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk   (read_clk),
    .clear (rst),
    .inc   (frame_err_q),
    .count (err_cnt)
  );
`endif

endmodule

// File: tb/tb_data_unpack.sv
// Bench for data_unpack: per-cycle vector table plus hand sequences for back-to-back,
// reset mid-frame and (with DATA_UNPACK_STATS_EN) counter saturation.
module tb_data_unpack;

  logic        read_clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [10:0] in_num;
  logic [31:0] f0_num;
  logic [31:0] fx_num;
  logic        frame_valid;
  logic        frame_err;
  logic        busy;
`ifdef DATA_UNPACK_STATS_EN
  logic [7:0]  frame_cnt;
  logic [7:0]  err_cnt;
`endif

  data_unpack #(.CNT_W(8)) dut (
    .read_clk    (read_clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_num      (in_num),
    .f0_num      (f0_num),
    .fx_num      (fx_num),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .busy        (busy)
`ifdef DATA_UNPACK_STATS_EN
    ,
    .frame_cnt   (frame_cnt),
    .err_cnt     (err_cnt)
`endif
  );

  // clock / reset
  always #5 read_clk = ~read_clk;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;
  always @(posedge read_clk) cyc++;

  typedef struct {
    logic        v;
    logic [2:0]  idx;
    logic [7:0]  b;
    logic        e_fv;
    logic        e_fe;
    logic        e_busy;
    logic [31:0] e_f0;
    logic [31:0] e_fx;
  } vec_t;

  vec_t vecs[$];

  logic [63:0] exp_q[$];
  int          pulse_cyc[$];
  logic        sb_on = 1'b0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] idx, input logic [7:0] b);
    in_valid = v;
    in_num   = {idx, b};
  endtask

  task automatic tick();
    @(posedge read_clk);
    #1;
  endtask

  function automatic void add(input logic v, input logic [2:0] idx, input logic [7:0] b,
                              input logic fv, input logic fe, input logic bs,
                              input logic [31:0] f0, input logic [31:0] fx);
    vec_t t;
    t.v = v; t.idx = idx; t.b = b;
    t.e_fv = fv; t.e_fe = fe; t.e_busy = bs; t.e_f0 = f0; t.e_fx = fx;
    vecs.push_back(t);
  endfunction

  function automatic logic [71:0] outs();
    return {5'd0, frame_valid, frame_err, busy, f0_num, fx_num};
  endfunction

  // scoreboard: frames expected while sb_on
  always @(negedge read_clk) begin
    if (sb_on && frame_valid) begin
      pulse_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL sb_unexpected_frame: got %h_%h expected none", fx_num, f0_num);
      end else begin
        check("sb_frame", {8'd0, fx_num, f0_num}, {8'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    logic [7:0]  fb [8];
    logic [31:0] p1_f0, p1_fx, p2_f0, p2_fx, p3_f0, p3_fx, p4_f0, p4_fx;

    p1_f0 = 32'h12345678; p1_fx = 32'hABCDEF09;
    p2_f0 = 32'h04030201; p2_fx = 32'h08070605;
    p3_f0 = 32'h40302010; p3_fx = 32'h80706050;
    p4_f0 = 32'hA3A2A1A0; p4_fx = 32'hA7A6A5A4;

    // single clean frame
    add(1, 0, 8'h78, 0, 0, 1, 0, 0);
    add(1, 1, 8'h56, 0, 0, 1, 0, 0);
    add(1, 2, 8'h34, 0, 0, 1, 0, 0);
    add(1, 3, 8'h12, 0, 0, 1, 0, 0);
    add(1, 4, 8'h09, 0, 0, 1, 0, 0);
    add(1, 5, 8'hEF, 0, 0, 1, 0, 0);
    add(1, 6, 8'hCD, 0, 0, 1, 0, 0);
    add(1, 7, 8'hAB, 1, 0, 0, p1_f0, p1_fx);
    add(0, 0, 8'h00, 0, 0, 0, p1_f0, p1_fx);
    // in_valid drops after idx 3
    add(1, 0, 8'h11, 0, 0, 1, p1_f0, p1_fx);
    add(1, 1, 8'h22, 0, 0, 1, p1_f0, p1_fx);
    add(1, 2, 8'h33, 0, 0, 1, p1_f0, p1_fx);
    add(1, 3, 8'h44, 0, 0, 1, p1_f0, p1_fx);
    add(0, 4, 8'h55, 0, 1, 0, p1_f0, p1_fx);
    add(0, 0, 8'h00, 0, 0, 0, p1_f0, p1_fx);
    for (int i = 0; i < 7; i++) add(1, 3'(i), 8'(i + 1), 0, 0, 1, p1_f0, p1_fx);
    add(1, 7, 8'h08, 1, 0, 0, p2_f0, p2_fx);
    // joining mid-stream
    add(1, 5, 8'hAA, 0, 0, 0, p2_f0, p2_fx);
    add(1, 6, 8'hBB, 0, 0, 0, p2_f0, p2_fx);
    add(1, 7, 8'hCC, 0, 0, 0, p2_f0, p2_fx);
    for (int i = 0; i < 7; i++) add(1, 3'(i), 8'((i + 1) * 16), 0, 0, 1, p2_f0, p2_fx);
    add(1, 7, 8'h80, 1, 0, 0, p3_f0, p3_fx);
    add(0, 0, 8'h00, 0, 0, 0, p3_f0, p3_fx);
    // restart on unexpected idx 0
    add(1, 0, 8'hF0, 0, 0, 1, p3_f0, p3_fx);
    add(1, 1, 8'hF1, 0, 0, 1, p3_f0, p3_fx);
    add(1, 2, 8'hF2, 0, 0, 1, p3_f0, p3_fx);
    add(1, 0, 8'hA0, 0, 1, 1, p3_f0, p3_fx);
    for (int i = 1; i < 7; i++) add(1, 3'(i), 8'hA0 + 8'(i), 0, 0, 1, p3_f0, p3_fx);
    add(1, 7, 8'hA7, 1, 0, 0, p4_f0, p4_fx);
    // skipped index aborts to HUNT; following non-zero idx discarded
    add(1, 0, 8'h55, 0, 0, 1, p4_f0, p4_fx);
    add(1, 1, 8'h66, 0, 0, 1, p4_f0, p4_fx);
    add(1, 3, 8'h77, 0, 1, 0, p4_f0, p4_fx);
    add(1, 4, 8'h88, 0, 0, 0, p4_f0, p4_fx);
    add(0, 0, 8'h00, 0, 0, 0, p4_f0, p4_fx);

    // reset state
    rst = 1'b1;
    drive(0, 0, 0);
    tick();
    tick();
    check("reset_outputs", outs(), 72'd0);
    rst = 1'b0;

    foreach (vecs[k]) begin
      drive(vecs[k].v, vecs[k].idx, vecs[k].b);
      tick();
      check($sformatf("vec%0d", k), outs(),
            {5'd0, vecs[k].e_fv, vecs[k].e_fe, vecs[k].e_busy, vecs[k].e_f0, vecs[k].e_fx});
    end

    // two frames back-to-back, in_valid never drops
    sb_on = 1'b1;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 8; i++) fb[i] = 8'h30 + 8'(f * 16 + i);
      exp_q.push_back({fb[7], fb[6], fb[5], fb[4], fb[3], fb[2], fb[1], fb[0]});
      for (int i = 0; i < 8; i++) begin
        drive(1, 3'(i), fb[i]);
        tick();
      end
    end
    drive(0, 0, 0);
    tick();
    tick();
    sb_on = 1'b0;
    check("b2b_pulses", 72'(pulse_cyc.size()), 72'd2);
    if (pulse_cyc.size() == 2) check("b2b_gap", 72'(pulse_cyc[1] - pulse_cyc[0]), 72'd8);
    check("b2b_leftover", 72'(exp_q.size()), 72'd0);
    check("b2b_hold", {8'd0, fx_num, f0_num}, {8'd0, 32'h47464544, 32'h43424140});

    // reset asserted at the idx-4 beat
    for (int i = 0; i < 4; i++) begin
      drive(1, 3'(i), 8'h90 + 8'(i));
      tick();
    end
    drive(1, 4, 8'h94);
    rst = 1'b1;
    tick();
    check("rst_mid_frame", outs(), 72'd0);
    rst = 1'b0;
    for (int i = 5; i < 8; i++) begin
      drive(1, 3'(i), 8'h90 + 8'(i));
      tick();
      check($sformatf("rst_tail_idx%0d", i), outs(), 72'd0);
    end
    for (int i = 0; i < 8; i++) begin
      drive(1, 3'(i), 8'hC0 + 8'(i));
      tick();
    end
    check("post_rst_frame", outs(), {5'd0, 3'b100, 32'hC3C2C1C0, 32'hC7C6C5C4});
    drive(0, 0, 0);
    tick();

`ifdef DATA_UNPACK_STATS_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("stats_reset", {56'd0, frame_cnt, err_cnt}, 72'd0);
    drive(1, 0, 8'h01);
    tick();
    drive(0, 0, 0);
    tick();
    tick();
    check("stats_err_one", {64'd0, err_cnt}, 72'd1);
    for (int f = 0; f < 300; f++) begin
      for (int i = 0; i < 8; i++) begin
        drive(1, 3'(i), 8'(f + i));
        tick();
      end
    end
    drive(0, 0, 0);
    tick();
    tick();
    check("stats_frame_sat", {64'd0, frame_cnt}, 72'hFF);
    check("stats_err_hold", {64'd0, err_cnt}, 72'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
